sdram_arbiter: RTL and testbench

- Sits directly upstream of the 32 MHz SDRAM controller and is the only block driving its cs/we/refresh/addr/din/ds inputs.
- Multiplexes three sources onto the controller's single-access slots: the periodic refresh timer, the video fetch port (real-time) and the CPU port.
- Generates the cs rising edge each controller cycle needs, captures read data and returns a one-cycle ack per client.

---
 rtl/sdram_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: refresh / video / CPU access arbiter for the SDRAM controller.
// Each access is one slot: IDLE grant, SLOT_LEN-1 cycles of cs high, one GAP cycle.
module sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 250,
    parameter int SLOT_LEN         = 8,
    parameter int READ_SAMPLE      = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram_ready,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_refresh,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [1:0]  ram_ds,
    input  logic [15:0] ram_dout,
    input  logic        vid_req,
    input  logic [21:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_ds,
    output logic        cpu_ack,
    output logic [15:0] cpu_dout,
    output logic        refresh_overrun
);

    localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int CW = $clog2(SLOT_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SLOT,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        OWN_REF,
        OWN_VID,
        OWN_CPU
    } owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    pend_q, pend_d;
    logic          ovr_q, ovr_d;
    logic          we_q, we_d;
    logic          ref_q, ref_d;
    logic [21:0]   addr_q, addr_d;
    logic [15:0]   din_q, din_d;
    logic [1:0]    ds_q, ds_d;
    logic [15:0]   vdout_q, vdout_d;
    logic [15:0]   cdout_q, cdout_d;

    logic sample;
    logic wrap;
    logic grant_ref;
    logic grant_vid;
    logic grant_cpu;

    assign sample  = (state_q == SLOT) && (cnt_q == CW'(READ_SAMPLE));
    assign vid_ack = sample && (owner_q == OWN_VID);
    assign cpu_ack = sample && (owner_q == OWN_CPU);
    assign wrap    = (timer_q == TW'(REFRESH_INTERVAL - 1));

    // Fixed priority: owed refreshes first, then video, then CPU.
    always_comb begin
        grant_ref = 1'b0;
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (ram_ready && (state_q == IDLE)) begin
            if (pend_q != 3'd0) begin
                grant_ref = 1'b1;
            end else if (vid_req && !vid_ack) begin
                grant_vid = 1'b1;
            end else if (cpu_req && !cpu_ack) begin
                grant_cpu = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        timer_d = wrap ? '0 : timer_q + 1'b1;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        we_d    = we_q;
        ref_d   = ref_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ds_d    = ds_q;
        vdout_d = vdout_q;
        cdout_d = cdout_q;

        unique case (state_q)
            IDLE: begin
                if (grant_ref || grant_vid || grant_cpu) begin
                    state_d = SLOT;
                    cnt_d   = '0;
                end
            end
            SLOT: begin
                if (cnt_q == CW'(SLOT_LEN - 2)) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (grant_ref) begin
            owner_d = OWN_REF;
            we_d    = 1'b0;
            ref_d   = 1'b1;
        end
        if (grant_vid) begin
            owner_d = OWN_VID;
            we_d    = 1'b0;
            ref_d   = 1'b0;
            addr_d  = vid_addr;
            ds_d    = 2'b00;
        end
        if (grant_cpu) begin
            owner_d = OWN_CPU;
            we_d    = cpu_we;
            ref_d   = 1'b0;
            addr_d  = cpu_addr;
            din_d   = cpu_din;
            ds_d    = cpu_ds;
        end

        // A wrap and a refresh grant in the same cycle cancel out.
        if (wrap && !grant_ref) begin
            if (pend_q != 3'd7) begin
                pend_d = pend_q + 3'd1;
            end
        end else if (!wrap && grant_ref) begin
            pend_d = pend_q - 3'd1;
        end

        if (vid_ack) begin
            vdout_d = ram_dout;
        end
        if (cpu_ack && !we_q) begin
            cdout_d = ram_dout;
        end

        if (!ram_ready) begin
            state_d = IDLE;
            owner_d = OWN_REF;
            cnt_d   = '0;
            timer_d = '0;
            pend_d  = 3'd0;
            we_d    = 1'b0;
            ref_d   = 1'b0;
            addr_d  = '0;
            din_d   = '0;
            ds_d    = 2'b11;
            vdout_d = '0;
            cdout_d = '0;
        end

        if (pend_d == 3'd7) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_REF;
            cnt_q   <= '0;
            timer_q <= '0;
            pend_q  <= 3'd0;
            ovr_q   <= 1'b0;
            we_q    <= 1'b0;
            ref_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ds_q    <= 2'b11;
            vdout_q <= '0;
            cdout_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            we_q    <= we_d;
            ref_q   <= ref_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ds_q    <= ds_d;
            vdout_q <= vdout_d;
            cdout_q <= cdout_d;
        end
    end

    // Read data reaches the client in the sample cycle itself, then is held.
    assign ram_cs          = (state_q == SLOT);
    assign ram_we          = we_q;
    assign ram_refresh     = ref_q;
    assign ram_addr        = addr_q;
    assign ram_din         = din_q;
    assign ram_ds          = ds_q;
    assign vid_dout        = vid_ack ? ram_dout : vdout_q;
    assign cpu_dout        = (cpu_ack && !we_q) ? ram_dout : cdout_q;
    assign refresh_overrun = ovr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: two arbiters (default and fast refresh) checked every
// cycle against a slot-level model, plus directed timing scenarios.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int SL  = 8;
    localparam int RS  = 6;
    localparam int RI0 = 250;
    localparam int RI1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [2];
    logic        rdy   [2];
    logic        cs    [2];
    logic        we    [2];
    logic        rf    [2];
    logic [21:0] addr  [2];
    logic [15:0] din   [2];
    logic [1:0]  ds    [2];
    logic [15:0] rdout [2];
    logic        vreq  [2];
    logic [21:0] vaddr [2];
    logic        vack  [2];
    logic [15:0] vdout [2];
    logic        creq  [2];
    logic        cwe   [2];
    logic [21:0] caddr [2];
    logic [15:0] cdin  [2];
    logic [1:0]  cds   [2];
    logic        cack  [2];
    logic [15:0] cdout [2];
    logic        ovr   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sdram_arbiter #(
            .REFRESH_INTERVAL(g == 0 ? RI0 : RI1),
            .SLOT_LEN        (SL),
            .READ_SAMPLE     (RS)
        ) u_dut (
            .clk            (clk),
            .reset_n        (rstn[g]),
            .ram_ready      (rdy[g]),
            .ram_cs         (cs[g]),
            .ram_we         (we[g]),
            .ram_refresh    (rf[g]),
            .ram_addr       (addr[g]),
            .ram_din        (din[g]),
            .ram_ds         (ds[g]),
            .ram_dout       (rdout[g]),
            .vid_req        (vreq[g]),
            .vid_addr       (vaddr[g]),
            .vid_ack        (vack[g]),
            .vid_dout       (vdout[g]),
            .cpu_req        (creq[g]),
            .cpu_we         (cwe[g]),
            .cpu_addr       (caddr[g]),
            .cpu_din        (cdin[g]),
            .cpu_ds         (cds[g]),
            .cpu_ack        (cack[g]),
            .cpu_dout       (cdout[g]),
            .refresh_overrun(ovr[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: mk = cycles since grant (0 = nothing in flight).
    int          mk    [2];
    int          mtim  [2];
    int          mpend [2];
    int          mwin  [2];
    logic        movr  [2];
    logic        mwe   [2];
    logic        mref  [2];
    logic [21:0] maddr [2];
    logic [15:0] mdin  [2];
    logic [1:0]  mds   [2];
    logic [15:0] mvd   [2];
    logic [15:0] mcd   [2];

    logic vack_seen [2];
    logic cack_seen [2];
    logic rnd_en    [2];
    logic vhold     [2];
    int   run       [2];
    int   pre_cs = 0;

    int          rq_cyc  [$];
    logic [21:0] rq_addr [$];
    logic        rq_ref  [$];

    task automatic mclear(input int k, input bit keep_ovr);
        mk[k] = 0; mtim[k] = 0; mpend[k] = 0; mwin[k] = 0;
        if (!keep_ovr) movr[k] = 1'b0;
        mwe[k] = 1'b0; mref[k] = 1'b0;
        maddr[k] = '0; mdin[k] = '0; mds[k] = 2'b11;
        mvd[k] = '0; mcd[k] = '0;
    endtask

    always @(negedge clk) begin
        logic        e_cs, e_va, e_ca, wrap;
        logic [15:0] e_vd, e_cd;
        int          g, np, ri;
        for (int k = 0; k < 2; k++) begin
            if (!rstn[k]) mclear(k, 1'b0);
            e_cs = (mk[k] >= 1) && (mk[k] <= SL - 1);
            e_va = e_cs && (mk[k] - 1 == RS) && (mwin[k] == 1);
            e_ca = e_cs && (mk[k] - 1 == RS) && (mwin[k] == 2);
            e_vd = e_va ? rdout[k] : mvd[k];
            e_cd = (e_ca && !mwe[k]) ? rdout[k] : mcd[k];
            total++;
            if ({cs[k], we[k], rf[k], addr[k], din[k], ds[k], vack[k],
                 vdout[k], cack[k], cdout[k], ovr[k]} !==
                {e_cs, mwe[k], mref[k], maddr[k], mdin[k], mds[k], e_va,
                 e_vd, e_ca, e_cd, movr[k]}) begin
                bad++;
                $display("FAIL model%0d cyc=%0d got/exp cs=%b/%b we=%b/%b rf=%b/%b addr=%h/%h din=%h/%h ds=%b/%b vack=%b/%b vdout=%h/%h cack=%b/%b cdout=%h/%h ovr=%b/%b",
                         k, cyc, cs[k], e_cs, we[k], mwe[k], rf[k], mref[k],
                         addr[k], maddr[k], din[k], mdin[k], ds[k], mds[k],
                         vack[k], e_va, vdout[k], e_vd, cack[k], e_ca,
                         cdout[k], e_cd, ovr[k], movr[k]);
            end
            vack_seen[k] = vack[k];
            cack_seen[k] = cack[k];
            if (rstn[k] && !rdy[k]) begin
                mclear(k, 1'b1);
            end else if (rstn[k]) begin
                ri = (k == 0) ? RI0 : RI1;
                wrap = (mtim[k] == ri - 1);
                mtim[k] = wrap ? 0 : mtim[k] + 1;
                g = 0;
                if (mk[k] == 0) begin
                    if (mpend[k] > 0) g = 3;
                    else if (vreq[k] && !e_va) g = 1;
                    else if (creq[k] && !e_ca) g = 2;
                end
                if (e_va) mvd[k] = rdout[k];
                if (e_ca && !mwe[k]) mcd[k] = rdout[k];
                if (g == 3) begin
                    mwin[k] = 0; mwe[k] = 1'b0; mref[k] = 1'b1;
                end else if (g == 1) begin
                    mwin[k] = 1; mwe[k] = 1'b0; mref[k] = 1'b0;
                    maddr[k] = vaddr[k]; mds[k] = 2'b00;
                end else if (g == 2) begin
                    mwin[k] = 2; mwe[k] = cwe[k]; mref[k] = 1'b0;
                    maddr[k] = caddr[k]; mdin[k] = cdin[k]; mds[k] = cds[k];
                end
                if (g != 0) mk[k] = 1;
                else if (mk[k] != 0) mk[k] = (mk[k] == SL) ? 0 : mk[k] + 1;
                np = mpend[k] + (wrap ? 1 : 0) - (g == 3 ? 1 : 0);
                if (np > 7) np = 7;
                mpend[k] = np;
                if (np == 7) movr[k] = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) run[k] = cs[k] ? run[k] + 1 : 0;
        if (cs[0] && run[0] == 1) begin
            rq_cyc.push_back(cyc);
            rq_addr.push_back(addr[0]);
            rq_ref.push_back(rf[0]);
        end
        if (!rdy[0] && cs[0]) pre_cs++;
    end

    // Clients: drop req the cycle after ack; optional random traffic.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (vack_seen[k] && !vhold[k]) vreq[k] = 1'b0;
            if (cack_seen[k]) creq[k] = 1'b0;
            if (rnd_en[k]) begin
                rdout[k] = 16'($urandom);
                if (!vreq[k] && !vack_seen[k] && $urandom_range(0, 5) == 0) begin
                    vaddr[k] = 22'($urandom);
                    vreq[k]  = 1'b1;
                end
                if (!creq[k] && !cack_seen[k] && $urandom_range(0, 3) == 0) begin
                    caddr[k] = 22'($urandom);
                    cdin[k]  = 16'($urandom);
                    cds[k]   = 2'($urandom);
                    cwe[k]   = 1'($urandom);
                    creq[k]  = 1'b1;
                end
            end
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic pstep();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int t_rdy, r0, w0, n, acks;
    bit found;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0; rdy[k] = 1'b0; vreq[k] = 1'b0; creq[k] = 1'b0;
            vaddr[k] = '0; caddr[k] = '0; cdin[k] = '0; cds[k] = 2'b11;
            cwe[k] = 1'b0; rdout[k] = '0; rnd_en[k] = 1'b0; vhold[k] = 1'b0;
            vack_seen[k] = 1'b0; cack_seen[k] = 1'b0; run[k] = 0;
        end
        repeat (3) nstep();
        check("reset_ds", ds[0], 2'b11);
        check("reset_cs", cs[0], 0);
        pstep();
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        repeat (100) pstep();
        check("no_cs_before_ready", pre_cs, 0);

        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        t_rdy = cyc;
        rq_cyc.delete(); rq_addr.delete(); rq_ref.delete();
        for (int i = 0; i < 400 && rq_cyc.size() == 0; i++) nstep();
        check("first_ref_seen", rq_cyc.size() > 0, 1);
        if (rq_cyc.size() > 0) begin
            check("first_ref_cyc", rq_cyc[0], t_rdy + RI0 + 1);
            check("first_ref_flag", rq_ref[0], 1);
        end
        n = 0;
        while (cs[0] && n < 20) begin n++; nstep(); end
        check("first_ref_len", n, SL - 1);

        // CPU read
        rdout[0] = 16'hBEEF;
        pstep();
        caddr[0] = 22'h12345; cwe[0] = 1'b0; cds[0] = 2'b00;
        cdin[0] = 16'h0; creq[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            nstep();
            if (cack[0]) begin
                found = 1;
                check("rd_dout", cdout[0], 16'hBEEF);
                check("rd_addr", addr[0], 22'h12345);
                check("rd_we", we[0], 0);
                check("rd_ds", ds[0], 2'b00);
                check("rd_ack_at_cnt6", run[0], RS + 1);
            end
        end
        check("rd_ack_seen", found, 1);
        nstep();
        check("rd_ack_one_cycle", cack[0], 0);

        // CPU write
        pstep();
        caddr[0] = 22'h000010; cdin[0] = 16'hA55A; cds[0] = 2'b10;
        cwe[0] = 1'b1; creq[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            nstep();
            if (cs[0] && run[0] == 1 && !rf[0] && addr[0] == 22'h000010)
                found = 1;
        end
        check("wr_slot_seen", found, 1);
        acks = 0; n = 0;
        while (cs[0] && n < 20) begin
            check("wr_stable", {we[0], din[0], ds[0]}, {1'b1, 16'hA55A, 2'b10});
            acks += int'(cack[0]);
            n++;
            nstep();
        end
        check("wr_ack_count", acks, 1);
        check("wr_dout_kept", cdout[0], 16'hBEEF);

        // Simultaneous video and CPU requests, issued during a refresh slot
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            nstep();
            if (cs[0] && run[0] == 1 && rf[0]) found = 1;
        end
        check("sim_ref_seen", found, 1);
        r0 = cyc;
        rq_cyc.delete(); rq_addr.delete(); rq_ref.delete();
        pstep();
        vaddr[0] = 22'h2AAAA; vreq[0] = 1'b1;
        caddr[0] = 22'h3BBBB; cwe[0] = 1'b0; cds[0] = 2'b01; creq[0] = 1'b1;
        for (int i = 0; i < 60 && rq_cyc.size() < 2; i++) nstep();
        check("sim_two_slots", rq_cyc.size() >= 2, 1);
        if (rq_cyc.size() >= 2) begin
            check("sim_vid_first", rq_addr[0], 22'h2AAAA);
            check("sim_vid_cyc", rq_cyc[0], r0 + 9);
            check("sim_cpu_second", rq_addr[1], 22'h3BBBB);
            check("sim_cpu_gap9", rq_cyc[1] - rq_cyc[0], 9);
        end

        // Refresh wrap landing inside a CPU slot, video waiting
        repeat (20) nstep();
        w0 = t_rdy + RI0 * ((cyc - t_rdy) / RI0 + 1);
        if (w0 - 4 <= cyc + 2) w0 += RI0;
        while (cyc < w0 - 4) pstep();
        rq_cyc.delete(); rq_addr.delete(); rq_ref.delete();
        caddr[0] = 22'h00C0DE; cwe[0] = 1'b0; cds[0] = 2'b00; creq[0] = 1'b1;
        pstep();
        pstep();
        vaddr[0] = 22'h155555; vreq[0] = 1'b1;
        for (int i = 0; i < 60 && rq_cyc.size() < 3; i++) nstep();
        check("wrap_three_slots", rq_cyc.size() >= 3, 1);
        if (rq_cyc.size() >= 3) begin
            check("wrap_cpu_cyc", rq_cyc[0], w0 - 3);
            check("wrap_cpu_addr", rq_addr[0], 22'h00C0DE);
            check("wrap_ref_cyc", rq_cyc[1], w0 + 6);
            check("wrap_ref_flag", rq_ref[1], 1);
            check("wrap_vid_cyc", rq_cyc[2], w0 + 15);
            check("wrap_vid_after", {rq_ref[2], rq_addr[2]}, {1'b0, 22'h155555});
        end

        // Random traffic on both arbiters
        rnd_en[0] = 1'b1;
        rnd_en[1] = 1'b1;
        repeat (3000) pstep();
        rnd_en[0] = 1'b0;
        rnd_en[1] = 1'b0;
        repeat (40) pstep();

        // Fast-refresh arbiter: continuous video pressure saturates pending
        vaddr[1] = 22'h1; vhold[1] = 1'b1; vreq[1] = 1'b1;
        repeat (150) pstep();
        check("ovr_set", ovr[1], 1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            nstep();
            if (cs[1] && run[1] == 3) found = 1;
        end
        check("midslot_seen", found, 1);
        #1;
        rstn[1] = 1'b0;
        #1;
        check("async_rst_cs", cs[1], 0);
        check("async_rst_ovr", ovr[1], 0);
        check("async_rst_ds", ds[1], 2'b11);
        repeat (3) pstep();
        rstn[1] = 1'b1;
        vhold[1] = 1'b0;
        repeat (60) pstep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
